// File: rtl/clk_en_gen_pkg.sv
// rtl/clk_en_gen_pkg.sv - shared types and constants for the clock-enable generator
package clk_en_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } chan_state_t;

  localparam int DEF_DIV_W   = 8;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/clk_en_gen_if.sv
// rtl/clk_en_gen_if.sv - request/divider/enable bundle between control block and generator
// active_o exists only when CLK_EN_GEN_STATUS_EN is defined.
interface clk_en_gen_if
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DEF_DIV_W
);

  logic [NUM_CH-1:0]       req_i;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       ce_o;
`ifdef CLK_EN_GEN_STATUS_EN
  logic [NUM_CH-1:0]       active_o;

  modport master (output req_i, output div_i, input ce_o, input active_o);
  modport slave  (input req_i, input div_i, output ce_o, output active_o);
`else
  modport master (output req_i, output div_i, input ce_o);
  modport slave  (input req_i, input div_i, output ce_o);
`endif

endinterface

// File: rtl/clk_en_chan.sv
// rtl/clk_en_chan.sv - one enable channel: optional synchroniser, polarity, FSM, divider counter
// o_active exists only when CLK_EN_GEN_STATUS_EN is defined.
module clk_en_chan
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter bit ASYNC   = 1'b0,
  parameter bit REQ_INV = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_req,
  input  logic [DIV_W-1:0] i_div,
`ifdef CLK_EN_GEN_STATUS_EN
  output logic             o_active,
`endif
  output logic             o_ce
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic             w_req_s;
  logic             w_req_eff;
  logic             w_wrap;
  chan_state_t      r_state;
  logic [DIV_W-1:0] r_cnt;
  logic             r_ce;

  generate
    if (ASYNC) begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
      end
      assign w_req_s = r_sync[SYNC_STAGES-1];
    end else begin : g_direct
      assign w_req_s = i_req;
    end
  endgenerate

  // Inversion sits after the synchroniser so an inverted low pin runs straight out of reset.
  assign w_req_eff = w_req_s ^ REQ_INV;
  assign w_wrap    = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ce    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ce  <= 1'b0;
          r_cnt <= '0;
          if (w_req_eff) begin
            r_state <= RUN;
            r_cnt   <= i_div;
          end
        end
        RUN: begin
          r_ce  <= w_wrap;
          r_cnt <= w_wrap ? i_div : r_cnt - CNT_ONE;
          if (!w_req_eff) r_state <= DRAIN;
        end
        DRAIN: begin
          r_ce <= w_wrap;
          if (w_wrap) begin
            r_state <= w_req_eff ? RUN : IDLE;
            r_cnt   <= w_req_eff ? i_div : '0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
            if (w_req_eff) r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ce    <= 1'b0;
        end
      endcase
    end
  end

  assign o_ce = r_ce;

`ifdef CLK_EN_GEN_STATUS_EN
  logic r_active;

  // Held through the final pulse cycle of DRAIN, dropped on the following edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    r_active <= w_req_eff;
        RUN:     r_active <= 1'b1;
        DRAIN:   r_active <= 1'b1;
        default: r_active <= 1'b0;
      endcase
    end
  end

  assign o_active = r_active;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - multi-channel clock-enable generator top, one clk_en_chan per channel
// Optional status output active_o enabled by CLK_EN_GEN_STATUS_EN.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int              NUM_CH       = 4,
  parameter int              DIV_W        = DEF_DIV_W,
  parameter logic [NUM_CH-1:0] ASYNC_MASK   = '0,
  parameter logic [NUM_CH-1:0] REQ_INV_MASK = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  clk_en_gen_if.slave bus
);

  logic [NUM_CH-1:0] w_ce;
`ifdef CLK_EN_GEN_STATUS_EN
  logic [NUM_CH-1:0] w_active;
`endif

  generate
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      clk_en_chan #(
        .DIV_W   (DIV_W),
        .ASYNC   (ASYNC_MASK[ch]),
        .REQ_INV (REQ_INV_MASK[ch])
      ) u_chan (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (bus.req_i[ch]),
        .i_div    (bus.div_i[ch*DIV_W +: DIV_W]),
`ifdef CLK_EN_GEN_STATUS_EN
        .o_active (w_active[ch]),
`endif
        .o_ce     (w_ce[ch])
      );
    end
  endgenerate

  assign bus.ce_o = w_ce;
`ifdef CLK_EN_GEN_STATUS_EN
  assign bus.active_o = w_active;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - scoreboard bench: expected pulse edges queued per channel, monitor compares
module tb_clk_en_gen;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   exp_q [NCH][$];

  clk_en_gen_if #(.NUM_CH(NCH), .DIV_W(DW)) u_if ();

  clk_en_gen #(
    .NUM_CH       (NCH),
    .DIV_W        (DW),
    .ASYNC_MASK   (4'b0100),
    .REQ_INV_MASK (4'b0010)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int ch, input int edge_no);
    exp_q[ch].push_back(edge_no);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: each ce_o pulse is tagged with the edge that registered it.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
          check($sformatf("pulse_missing ch%0d edge %0d", ch, exp_q[ch][0]), 0, 1);
          void'(exp_q[ch].pop_front());
        end
        if (u_if.ce_o[ch]) begin
          if (exp_q[ch].size() == 0) check($sformatf("pulse_unexpected ch%0d", ch), 1, 0);
          else check($sformatf("pulse_edge ch%0d", ch), cyc, exp_q[ch].pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int s;
    int r;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    u_if.req_i = 4'b1111;
    u_if.div_i = '0;
    u_if.div_i[0*DW +: DW] = 8'd3;

    repeat (3) @(negedge clk);
    check("reset_ce", int'(u_if.ce_o), 0);
`ifdef CLK_EN_GEN_STATUS_EN
    check("reset_active", int'(u_if.active_o), 0);
`endif
    @(negedge clk);
    check("reset_ce_hold", int'(u_if.ce_o), 0);

    // ch0 sync D=3 from reset release
    reset_n    = 1'b1;
    u_if.req_i = 4'b0011;
    e0 = cyc + 1;
    push(0, e0 + 4); push(0, e0 + 8); push(0, e0 + 12);
`ifdef CLK_EN_GEN_STATUS_EN
    wait_cyc(e0 + 6);
    check("active_run_ch0", int'(u_if.active_o[0]), 1);
`endif
    wait_cyc(e0 + 9);
    u_if.req_i[0] = 1'b0;
`ifdef CLK_EN_GEN_STATUS_EN
    wait_cyc(e0 + 14);
    check("active_idle_ch0", int'(u_if.active_o[0]), 0);
`endif
    wait_cyc(e0 + 16);

    // ch1 (inverted) D=0: 10 cycles of request, then one further pulse
    s = cyc;
    u_if.req_i[1] = 1'b0;
    for (int k = 2; k <= 12; k++) push(1, s + k);
    wait_cyc(s + 10);
    u_if.req_i[1] = 1'b1;
    wait_cyc(s + 16);

    // ch2 async D=1: single-cycle request pulse
    s = cyc;
    u_if.div_i[2*DW +: DW] = 8'd1;
    u_if.req_i[2] = 1'b1;
    push(2, s + 5);
    wait_cyc(s + 1);
    u_if.req_i[2] = 1'b0;
    wait_cyc(s + 10);

    // ch2 async held request, deassert latency and wrap-coincident fall
    s = cyc;
    u_if.req_i[2] = 1'b1;
    push(2, s + 5); push(2, s + 7); push(2, s + 9); push(2, s + 11); push(2, s + 13);
    wait_cyc(s + 8);
    u_if.req_i[2] = 1'b0;
    wait_cyc(s + 18);

    // ch0 D=5 drain recovery, then a clean stop
    s = cyc;
    u_if.div_i[0*DW +: DW] = 8'd5;
    u_if.req_i[0] = 1'b1;
    e0 = s + 1;
    push(0, e0 + 6); push(0, e0 + 12); push(0, e0 + 18); push(0, e0 + 24);
    wait_cyc(e0 + 7);
    u_if.req_i[0] = 1'b0;
    wait_cyc(e0 + 9);
    u_if.req_i[0] = 1'b1;
    wait_cyc(e0 + 19);
    u_if.req_i[0] = 1'b0;
    wait_cyc(e0 + 30);

    // ch3 D=7 -> 2 mid-period, then request falls on a wrap edge
    s = cyc;
    u_if.div_i[3*DW +: DW] = 8'd7;
    u_if.req_i[3] = 1'b1;
    e0 = s + 1;
    push(3, e0 + 8); push(3, e0 + 16); push(3, e0 + 19);
    push(3, e0 + 22); push(3, e0 + 25); push(3, e0 + 28);
    wait_cyc(e0 + 10);
    u_if.div_i[3*DW +: DW] = 8'd2;
    wait_cyc(e0 + 24);
    u_if.req_i[3] = 1'b0;
    wait_cyc(e0 + 34);

    // reset mid-pulse on ch0, ch1 inverted pin low through reset
    s = cyc;
    u_if.div_i[0*DW +: DW] = 8'd3;
    u_if.req_i[0] = 1'b1;
    e0 = s + 1;
    push(0, e0 + 4); push(0, e0 + 8);
    wait_cyc(e0 + 8);
    #2;
    reset_n = 1'b0;
    u_if.req_i[1] = 1'b0;
    #1;
    check("reset_async_ce", int'(u_if.ce_o), 0);
    repeat (3) @(negedge clk);
    check("reset_mid_ce", int'(u_if.ce_o), 0);
    r = cyc;
    reset_n = 1'b1;
    push(0, r + 5); push(0, r + 9);
    for (int k = 2; k <= 7; k++) push(1, r + k);
    wait_cyc(r + 5);
    u_if.req_i[0] = 1'b0;
    u_if.req_i[1] = 1'b1;
    wait_cyc(r + 15);

    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("queue_drained ch%0d", ch), exp_q[ch].size(), 0);
    check("final_ce", int'(u_if.ce_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
# clk_en_gen

Multi-channel, parametrised clock-enable generator: the synthesizable, divided successor of the single-buffer clock-enable primitive. Each of NUM_CH channels turns a level enable request into a periodic one-cycle enable pulse at clk/(div+1). Enable changes only take effect at period boundaries, so a downstream register stage never sees a truncated period. Sits between the control/register block and the sample-rate and operator pipelines, which clock on clk and qualify with ce_o.

## Interface
- NUM_CH, 4: number of independent channels (1..16)
- DIV_W, 8: divider width; period range 1..2^DIV_W cycles
- ASYNC_MASK, '0: per-channel bit; 1 = req_i[ch] is asynchronous and passes through a 2-flop synchroniser, 0 = req_i[ch] is synchronous to clk
- REQ_INV_MASK, '0: per-channel bit; 1 = req_i[ch] is active-low
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_i  in  NUM_CH  per-channel enable request (level)
- div_i  in  NUM_CH*DIV_W  per-channel divide value D; channel ch uses bits [ch*DIV_W +: DIV_W]
- ce_o  out  NUM_CH  per-channel one-cycle enable pulse, registered
- active_o  out  NUM_CH  channel running (only with CLK_EN_GEN_STATUS_EN)

## Operation
- Effective request: req_eff = (synchronised or direct req_i) XOR REQ_INV_MASK bit; the inversion is applied after the synchroniser.
- Per-channel FSM: IDLE, RUN, DRAIN. Per-channel down-counter cnt[DIV_W-1:0].
- IDLE: cnt held 0, ce_o 0. req_eff=1 -> RUN, cnt <= div_i.
- RUN: if cnt==0 -> ce_o <= 1, cnt <= div_i (reloaded at every wrap); else cnt <= cnt-1, ce_o <= 0. req_eff=0 -> DRAIN; the counter keeps running.
- DRAIN: counts as in RUN. At cnt==0: emit the final pulse, then go to IDLE if req_eff=0 or to RUN if req_eff=1. req_eff back to 1 before wrap -> RUN with no phase change and no missing pulse.
- Simultaneous events: req_eff falling on the same edge as a wrap -> pulse issued, state DRAIN, cnt reloaded; a full final period follows.
- div_i is sampled only on IDLE->RUN entry and at wrap; mid-period changes have no effect until the next wrap.
- D=0: pulse every cycle while running. D=2^DIV_W-1: period 2^DIV_W.
- Channels are fully independent; there is no cross-channel phase relation.

## Timing
- Reset (reset_n=0, asynchronous): all states IDLE, cnt 0, ce_o 0, active_o 0, synchroniser flops 0. Because of the post-sync inversion, an inverted channel whose pin is low starts running after release.
- Sync channel: request sampled at edge E0 -> first ce_o high in the cycle after edge E0+D+1. Subsequent pulses every D+1 cycles.
- Async channel: 2 additional cycles of latency on both assertion and deassertion.
- Stop: after req_eff falls, at most 1 further pulse (the current period's) plus a full period if the fall coincides with a wrap. ce_o is 0 from the cycle after that pulse.
- reset_n asserted mid-period: ce_o drops to 0 immediately (asynchronously), with no final pulse.
- active_o is high in RUN and DRAIN, and goes low on the edge after the final pulse.

## Configuration
- CLK_EN_GEN_STATUS_EN defined: the active_o port exists and is driven as above.
- CLK_EN_GEN_STATUS_EN undefined: the active_o port and its logic are absent. ce_o behaviour is identical in both builds.

## Structure
- clk_en_gen_pkg: chan_state_t enum (IDLE, RUN, DRAIN), default DIV_W constant, SYNC_STAGES=2 constant.
- Sub-module clk_en_chan: one channel (optional synchroniser, inversion, FSM, counter, ce register). Instantiated NUM_CH times by generate. The top level only slices req_i, div_i and the masks.

## Test plan
- Reset: hold reset_n=0 with all req_i=1 -> ce_o=0, active_o=0. Release with D=3 on ch0 (sync) -> first pulse 4 cycles after the first sampling edge, then every 4 cycles.
- D=0 on ch1: req 1 for 10 cycles -> ce_o high for 10 consecutive cycles starting 1 cycle after sampling. Drop req -> exactly 1 further pulse, then 0.
- ch2 async, D=1: req rises -> first pulse 2+2 cycles after rise. Req pulse 1 cycle wide, clean -> one full period (1 pulse) then IDLE.
- Drain recovery, ch0 D=5: drop req 2 cycles into the period, reassert 2 cycles later -> pulse spacing stays exactly 6 throughout, with no gap.
- Divider change, ch3 D=7 -> 2 mid-period -> the current period stays 8 cycles, subsequent periods are 3 cycles. Req falling on a wrap edge -> pulse plus one full 3-cycle period, then IDLE.
- REQ_INV_MASK[1]=1, pin held 0 through reset -> channel runs after release. reset_n pulsed low mid-period -> ce_o 0 immediately, restart timing as after a cold reset.
